// File: rtl/sauria_neg_pkg.sv
// Types and constants shared by the negligence-threshold controller and the
// per-PE zero/negligence detectors.
package sauria_neg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2
    } neg_ctrl_state_t;

    localparam int RATIO_ONE = 256;
    localparam int TH_W_DEF  = 2;

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a balanced binary adder tree.
module popcount_tree #(
    parameter int N_PE = 16
) (
    input  logic [N_PE-1:0]             i_bits,
    output logic [$clog2(N_PE+1)-1:0]   o_cnt
);

    localparam int CNT_W = $clog2(N_PE + 1);

    generate
        if (N_PE == 1) begin : g_leaf
            assign o_cnt = i_bits;
        end else begin : g_split
            localparam int LO_N = N_PE / 2;
            localparam int HI_N = N_PE - LO_N;

            logic [$clog2(LO_N+1)-1:0] lo_cnt;
            logic [$clog2(HI_N+1)-1:0] hi_cnt;

            popcount_tree #(.N_PE(LO_N)) u_lo (
                .i_bits (i_bits[LO_N-1:0]),
                .o_cnt  (lo_cnt)
            );

            popcount_tree #(.N_PE(HI_N)) u_hi (
                .i_bits (i_bits[N_PE-1:LO_N]),
                .o_cnt  (hi_cnt)
            );

            assign o_cnt = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/neg_thres_ctrl.sv
// Closed-loop controller that steps the shared negligence threshold once per
// window so the measured skip ratio tracks a software target.
module neg_thres_ctrl
    import sauria_neg_pkg::*;
#(
    parameter int N_PE  = 16,
    parameter int TH_W  = TH_W_DEF,
    parameter int WIN_W = 10,
    parameter int HYST  = 8
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_en,
    input  logic                                i_auto,
    input  logic [TH_W-1:0]                     i_thres_manual,
    input  logic [TH_W-1:0]                     i_thres_max,
    input  logic [7:0]                          i_target,
    input  logic [WIN_W-1:0]                    i_win_len,
    input  logic                                i_valid,
    input  logic [N_PE-1:0]                     i_zero_det,
    output logic [TH_W-1:0]                     o_thres,
    output logic                                o_win_done,
    output logic [WIN_W+$clog2(N_PE+1)-1:0]     o_skip_cnt,
    output logic                                o_busy
);

    localparam int CNT_W       = $clog2(N_PE + 1);
    localparam int SKIP_W      = WIN_W + CNT_W;
    localparam int PROD_W      = SKIP_W + 9;
    localparam int RATIO_SHIFT = $clog2(RATIO_ONE);

    function automatic logic [TH_W-1:0] th_min(input logic [TH_W-1:0] a,
                                               input logic [TH_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [TH_W-1:0] th_sat_inc(input logic [TH_W-1:0] a,
                                                   input logic [TH_W-1:0] lim);
        return (a >= lim) ? lim : a + TH_W'(1);
    endfunction

    function automatic logic [TH_W-1:0] th_sat_dec(input logic [TH_W-1:0] a);
        return (a == '0) ? '0 : a - TH_W'(1);
    endfunction

    neg_ctrl_state_t    state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [SKIP_W-1:0]  skip_acc_q, skip_acc_d;
    logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
    logic [TH_W-1:0]    thres_q, thres_d;
    logic               win_done_q, win_done_d;

    logic [CNT_W-1:0]   pop_cnt;
    logic [WIN_W-1:0]   win_eff;
    logic               win_last;
    logic [7:0]         t_lo, t_hi;
    logic [8:0]         t_sum;
    logic [PROD_W-1:0]  total, lhs, lo_bound, hi_bound;

    popcount_tree #(.N_PE(N_PE)) u_popcount (
        .i_bits (i_zero_det),
        .o_cnt  (pop_cnt)
    );

    // Window length 0 behaves as 1; bounds are exact products, never truncated.
    assign win_eff  = (i_win_len == '0) ? WIN_W'(1) : i_win_len;
    assign win_last = (win_cnt_q == win_eff - WIN_W'(1));
    assign t_sum    = {1'b0, i_target} + 9'(HYST);
    assign t_lo     = (i_target > 8'(HYST)) ? i_target - 8'(HYST) : 8'd0;
    assign t_hi     = (t_sum > 9'd255) ? 8'hFF : t_sum[7:0];
    assign total    = PROD_W'(win_eff) * PROD_W'(N_PE);
    assign lhs      = PROD_W'(skip_acc_q) << RATIO_SHIFT;
    assign lo_bound = PROD_W'(t_lo) * total;
    assign hi_bound = PROD_W'(t_hi) * total;

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        skip_acc_d = skip_acc_q;
        skip_cnt_d = skip_cnt_q;
        thres_d    = thres_q;
        win_done_d = (state_q == EVAL);

        case (state_q)
            IDLE: begin
                win_cnt_d  = '0;
                skip_acc_d = '0;
                if (i_auto) thres_d = th_min(thres_q, i_thres_max);
                if (i_en) state_d = ACCUM;
            end
            ACCUM: begin
                if (!i_en) begin
                    state_d    = IDLE;
                    win_cnt_d  = '0;
                    skip_acc_d = '0;
                end else if (i_valid) begin
                    skip_acc_d = skip_acc_q + SKIP_W'(pop_cnt);
                    win_cnt_d  = win_cnt_q + WIN_W'(1);
                    if (win_last) state_d = EVAL;
                end
            end
            EVAL: begin
                skip_cnt_d = skip_acc_q;
                win_cnt_d  = '0;
                skip_acc_d = '0;
                state_d    = i_en ? ACCUM : IDLE;
                if (i_auto) begin
                    if (lhs < lo_bound)
                        thres_d = th_sat_inc(thres_q, i_thres_max);
                    else if (lhs > hi_bound)
                        thres_d = th_min(th_sat_dec(thres_q), i_thres_max);
                    else
                        thres_d = th_min(thres_q, i_thres_max);
                end
            end
            default: state_d = IDLE;
        endcase

        // Manual mode overrides the threshold in every state.
        if (!i_auto) thres_d = i_thres_manual;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            skip_acc_q <= '0;
            skip_cnt_q <= '0;
            thres_q    <= '0;
            win_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            skip_acc_q <= skip_acc_d;
            skip_cnt_q <= skip_cnt_d;
            thres_q    <= thres_d;
            win_done_q <= win_done_d;
        end
    end

    assign o_thres    = thres_q;
    assign o_win_done = win_done_q;
    assign o_skip_cnt = skip_cnt_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_neg_thres_ctrl.sv
// Randomised and directed bench for neg_thres_ctrl with a window-level model
// and a scoreboard drained on every o_win_done pulse.
module tb_neg_thres_ctrl;

    localparam int N_PE  = 4;
    localparam int TH_W  = 2;
    localparam int WIN_W = 10;
    localparam int HYST  = 8;
    localparam int SK_W  = WIN_W + $clog2(N_PE + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               auto_m;
    logic [TH_W-1:0]    thres_manual;
    logic [TH_W-1:0]    thres_max;
    logic [7:0]         target;
    logic [WIN_W-1:0]   win_len;
    logic               valid;
    logic [N_PE-1:0]    zd;
    logic [TH_W-1:0]    thres;
    logic               win_done;
    logic [SK_W-1:0]    skip_cnt;
    logic               busy;

    neg_thres_ctrl #(.N_PE(N_PE), .TH_W(TH_W), .WIN_W(WIN_W), .HYST(HYST)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_auto         (auto_m),
        .i_thres_manual (thres_manual),
        .i_thres_max    (thres_max),
        .i_target       (target),
        .i_win_len      (win_len),
        .i_valid        (valid),
        .i_zero_det     (zd),
        .o_thres        (thres),
        .o_win_done     (win_done),
        .o_skip_cnt     (skip_cnt),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int skip;
        int thres;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: 0 = not collecting, 1 = collecting a window, 2 = window full, judging next cycle
    int   m_phase = 0;
    int   m_pcs[$];
    int   m_thres = 0;
    int   m_skip  = 0;
    int   m_done  = 0;

    function automatic void chk(string nm, longint act, longint exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step();
        int     eff;
        int     s;
        longint lhs, lo, hi, total;
        bit     judged;
        judged = 0;
        if (rst) begin
            m_phase = 0;
            m_pcs.delete();
            m_thres = 0;
            m_skip  = 0;
            m_done  = 0;
            return;
        end
        m_done = (m_phase == 2);
        eff = (win_len == 0) ? 1 : int'(win_len);
        case (m_phase)
            0: begin
                m_pcs.delete();
                if (auto_m) m_thres = imin(m_thres, int'(thres_max));
                if (en) m_phase = 1;
            end
            1: begin
                if (!en) begin
                    m_pcs.delete();
                    m_phase = 0;
                end else if (valid) begin
                    m_pcs.push_back($countones(zd));
                    if (m_pcs.size() == eff) m_phase = 2;
                end
            end
            default: begin
                s = 0;
                foreach (m_pcs[i]) s += m_pcs[i];
                total = longint'(eff) * N_PE;
                lhs   = longint'(s) * 256;
                lo    = longint'(imax(int'(target) - HYST, 0)) * total;
                hi    = longint'(imin(int'(target) + HYST, 255)) * total;
                if (auto_m) begin
                    if (lhs < lo)      m_thres = imin(m_thres + 1, int'(thres_max));
                    else if (lhs > hi) m_thres = imin(imax(m_thres - 1, 0), int'(thres_max));
                    else               m_thres = imin(m_thres, int'(thres_max));
                end
                m_skip = s;
                m_pcs.delete();
                m_phase = en ? 1 : 0;
                judged = 1;
            end
        endcase
        if (!auto_m) m_thres = int'(thres_manual);
        if (judged) sb.push_back('{skip: m_skip, thres: m_thres});
    endtask

    task automatic drive(input bit r, input bit e, input bit v, input int zv);
        rst   = r;
        en    = e;
        valid = v;
        zd    = N_PE'(zv);
        model_step();
        @(posedge clk);
        #1;
        chk("o_thres", thres, m_thres);
        chk("o_busy", busy, (m_phase != 0));
        chk("o_skip_cnt", skip_cnt, m_skip);
        chk("o_win_done", win_done, m_done);
    endtask

    always @(negedge clk) begin
        if (win_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_done: got pulse expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_skip_cnt", skip_cnt, e.skip);
                chk("sb_thres", thres, e.thres);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; en = 0; auto_m = 1; thres_manual = 0; thres_max = 3;
        target = 128; win_len = 4; valid = 0; zd = 0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("reset_thres", thres, 0);
        chk("reset_skip", skip_cnt, 0);

        // Low skip ratio: threshold climbs to the max and holds
        drive(0, 1, 0, 0);
        repeat (4) begin
            repeat (4) drive(0, 1, 1, 4'b0000);
            drive(0, 1, 0, 0);
        end
        chk("low_holds_at_max", thres, 3);

        // High skip ratio: threshold steps down and saturates at 0
        repeat (4) begin
            repeat (4) drive(0, 1, 1, 4'b1111);
            drive(0, 1, 0, 0);
        end
        chk("high_floor_zero", thres, 0);

        // Dead band: 8/16 skipped leaves the threshold alone
        repeat (4) drive(0, 1, 1, 4'b0000);
        drive(0, 1, 0, 0);
        repeat (4) drive(0, 1, 1, 4'b0011);
        drive(0, 1, 0, 0);
        chk("deadband_thres", thres, 1);
        chk("deadband_skip", skip_cnt, 8);

        // Valid gaps, then flags presented in the judging cycle must be dropped
        drive(0, 1, 1, 4'b1000);
        drive(0, 1, 0, 4'b1111);
        drive(0, 1, 0, 4'b1111);
        drive(0, 1, 1, 4'b1000);
        drive(0, 1, 1, 4'b1000);
        drive(0, 1, 0, 4'b1111);
        drive(0, 1, 1, 4'b1000);
        drive(0, 1, 1, 4'b1111);
        repeat (4) drive(0, 1, 1, 4'b0000);
        drive(0, 1, 0, 0);
        chk("gap_next_window_skip", skip_cnt, 0);

        // Manual mode, then lower max while idle
        auto_m = 0; thres_manual = 2;
        drive(0, 1, 0, 0);
        chk("manual_thres", thres, 2);
        repeat (4) drive(0, 1, 1, 4'b0110);
        drive(0, 1, 0, 0);
        chk("manual_stats", skip_cnt, 8);
        drive(0, 0, 0, 0);
        auto_m = 1; thres_max = 1;
        drive(0, 0, 0, 0);
        chk("max_clamp_idle", thres, 1);

        // Abort mid-window
        thres_max = 3;
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 4'b1111);
        drive(0, 1, 1, 4'b1111);
        drive(0, 0, 1, 4'b1111);
        drive(0, 0, 0, 0);
        chk("abort_skip_kept", skip_cnt, 8);

        // Reset mid-window
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 4'b0001);
        drive(0, 1, 1, 4'b0001);
        drive(1, 1, 1, 4'b0001);
        chk("rst_mid_thres", thres, 0);
        chk("rst_mid_busy", busy, 0);

        // Randomised windows; length only changes while not collecting
        for (int blk = 0; blk < 40; blk++) begin
            int steps;
            drive(0, 0, 0, 0);
            win_len      = WIN_W'($urandom_range(0, 5));
            target       = 8'($urandom_range(0, 255));
            thres_max    = TH_W'($urandom_range(0, 3));
            auto_m       = ($urandom_range(0, 5) != 0);
            thres_manual = TH_W'($urandom_range(0, 3));
            steps = $urandom_range(5, 30);
            for (int k = 0; k < steps; k++) begin
                if ($urandom_range(0, 15) == 0) thres_max = TH_W'($urandom_range(0, 3));
                drive(0, ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, 15)));
            end
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neg_thres_ctrl.md
Name: neg_thres_ctrl

Overview:
- Closed-loop controller for the negligence threshold consumed by the per-PE zero/negligence detectors in the systolic array.
- Collects the per-PE zero-detect flags each valid array cycle and counts skipped operations over a programmable window.
- At the end of each window, steps the shared threshold up or down so the measured skip ratio tracks a software target.
- Sits next to the systolic array; its threshold output fans out to every detector.

Parameters:
- N_PE, 16: number of zero-detect flags sampled per cycle.
- TH_W, 2: threshold width; must match the detectors.
- WIN_W, 10: window-length counter width, in valid cycles.
- HYST, 8: dead band around the target, in 1/256 units.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  controller enable
- i_auto  in  1  1 = adaptive threshold; 0 = manual threshold
- i_thres_manual  in  TH_W  threshold used when i_auto=0
- i_thres_max  in  TH_W  upper saturation limit for the adaptive threshold
- i_target  in  8  target skip ratio, in 1/256 units
- i_win_len  in  WIN_W  window length in valid cycles; 0 is treated as 1
- i_valid  in  1  array MAC cycle active; flags are meaningful
- i_zero_det  in  N_PE  per-PE zero/negligence flags
- o_thres  out  TH_W  threshold driven to all detectors (registered)
- o_win_done  out  1  one-cycle pulse in the cycle after EVAL
- o_skip_cnt  out  WIN_W+$clog2(N_PE+1)  skip count of the last completed window
- o_busy  out  1  state != IDLE

Behaviour:
- Reset values: o_thres=0, o_win_done=0, o_skip_cnt=0, o_busy=0, state=IDLE, internal counters=0.
- States are IDLE, ACCUM and EVAL.
- IDLE:
  - Move to ACCUM when i_en=1.
  - Clear the window counter (win_cnt) and the skip counter (skip_acc).
- ACCUM:
  - On each cycle with i_valid=1: skip_acc += popcount(i_zero_det) and win_cnt += 1.
  - Cycles with i_valid=0 change nothing.
  - When i_valid=1 and win_cnt == max(i_win_len,1)-1: that cycle's flags are counted, then the FSM moves to EVAL.
- EVAL (exactly one cycle):
  - i_valid flags in this cycle are discarded.
  - total = max(i_win_len,1)*N_PE.
  - lhs = skip_acc*256.
  - lo = max(i_target-HYST, 0) * total.
  - hi = min(i_target+HYST, 255) * total.
  - All products use full-width unsigned arithmetic with no truncation.
  - Adaptive update (i_auto=1): if lhs < lo, o_thres = min(o_thres+1, i_thres_max); else if lhs > hi, o_thres = o_thres-1, saturating at 0; else hold.
  - o_skip_cnt <= skip_acc.
  - Counters clear.
  - Next state is ACCUM if i_en=1, else IDLE.
  - o_win_done is asserted in the following cycle for 1 cycle.
- Manual mode (i_auto=0):
  - o_thres <= i_thres_manual every cycle, one-cycle latency.
  - Statistics and o_win_done still operate.
- Switching i_auto 0→1: adaptation starts from the current o_thres.
- If o_thres > i_thres_max (max lowered at runtime): o_thres is clamped to i_thres_max in the next EVAL, or immediately in IDLE.
- i_en deassert during ACCUM: go to IDLE next cycle; the partial window is discarded; o_thres and o_skip_cnt are retained; no o_win_done.
- Reset mid-window: all state returns to reset values on the next edge.
- o_thres changes only in the EVAL cycle or in manual mode, so detectors see a stable threshold for a whole window.

Decomposition:
- Shared package sauria_neg_pkg holds:
  - the FSM state enum neg_ctrl_state_t {IDLE, ACCUM, EVAL};
  - the ratio scale constant RATIO_ONE=256;
  - the TH_W default, shared with the detectors.
- One sub-module, popcount_tree:
  - parameterised by N_PE;
  - combinational adder tree producing $clog2(N_PE+1) bits.

Test Plan:
- Low skip ratio:
  - Setup: N_PE=4, i_win_len=4, i_target=128, HYST=8, i_auto=1, i_thres_max=3.
  - Stimulus: 4 valid cycles with i_zero_det=0000.
  - Required: o_skip_cnt=0, o_win_done pulse, o_thres 0→1; 3 more such windows → o_thres=3 and holds at 3.
- High skip ratio:
  - Stimulus: with o_thres=2, a window with i_zero_det=1111 on all 4 cycles (skip 16/16).
  - Required: o_thres=1; a further window gives 0; another stays 0.
- Dead band:
  - Stimulus: 8 of 16 skipped (lhs=2048, lo=1920, hi=2176).
  - Required: o_thres unchanged, o_skip_cnt=8.
- Valid gaps and EVAL discard:
  - Stimulus: i_valid toggled 1,0,0,1,1,0,1; flag 1111 presented in the EVAL cycle.
  - Required: window closes on the 4th valid cycle; EVAL-cycle flags are excluded from the next window's count.
- Manual mode and max change:
  - Stimulus: i_auto=0 with i_thres_manual=2.
  - Required: o_thres=2 after 1 cycle, stats still reported.
  - Stimulus: i_auto=1 and i_thres_max lowered to 1 while in IDLE.
  - Required: o_thres=1.
- Abort and reset:
  - Stimulus: i_en dropped after 2 of 4 valid cycles.
  - Required: IDLE, no o_win_done, o_skip_cnt unchanged.
  - Stimulus: i_rst asserted mid-ACCUM.
  - Required: all outputs 0 on the next cycle.
